julia_fb_writer: RTL and testbench

- Frame-compute engine for the Julia display path: the write side of the framebuffer BRAM that the display-side BRAM controller reads.
- Sweeps a downscaled FB_W x FB_H grid in raster order and iterates z = z^2 + c in signed fixed point.
- Writes each pixel's escape-iteration count to the BRAM write port, one write per pixel.
- Started by a one-cycle pulse from the button/v_sync control logic; c is supplied by that logic.

---
 rtl/julia_pkg.sv | 20 ++
 rtl/julia_iter_step.sv | 34 +++
 rtl/julia_fb_writer.sv | 167 ++++++++++++++++
 tb/tb_julia_fb_writer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// Shared constants, window defaults and state encoding for the Julia framebuffer engine.
// The optional Mandelbrot mode in julia_fb_writer is enabled by defining JULIA_MANDEL_EN.
package julia_pkg;

  localparam int FRAC_BITS    = 12;
  localparam int ESC_LIMIT    = 16384;
  localparam int DEF_MAX_ITER = 63;
  localparam int DEF_X0       = -8192;
  localparam int DEF_DX       = 51;
  localparam int DEF_Y0       = 4608;
  localparam int DEF_DY       = -51;

  typedef enum logic [1:0] {IDLE, INIT, ITER, WRITE} state_t;

  // The counter must be able to hold the cap itself, which is written for non-escaping pixels.
  function automatic int cnt_width(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/julia_iter_step.sv
// One combinational z = z^2 + c evaluation in signed Q4.12, with the escape test on the incoming z.
module julia_iter_step
  import julia_pkg::*;
#(
  parameter int FRAC = FRAC_BITS
) (
  input  logic signed [15:0] z_re,
  input  logic signed [15:0] z_im,
  input  logic signed [15:0] c_re,
  input  logic signed [15:0] c_im,
  output logic signed [15:0] nz_re,
  output logic signed [15:0] nz_im,
  output logic               escape
);

  logic signed [31:0] p_re2, p_im2, p_reim;
  logic signed [19:0] re2, im2, reim;
  logic signed [20:0] mag;

  // Squares can reach 2^18 each after the shift, so the magnitude sum needs a 21st bit.
  always_comb begin
    p_re2  = 32'(z_re) * 32'(z_re);
    p_im2  = 32'(z_im) * 32'(z_im);
    p_reim = 32'(z_re) * 32'(z_im);
    re2    = 20'(p_re2 >>> FRAC);
    im2    = 20'(p_im2 >>> FRAC);
    reim   = 20'(p_reim >>> FRAC);
    mag    = 21'(re2) + 21'(im2);
    escape = mag > 21'(ESC_LIMIT);
    nz_re  = 16'(re2 - im2 + 20'(c_re));
    nz_im  = 16'(reim + reim + 20'(c_im));
  end

endmodule

// File: rtl/julia_fb_writer.sv
// Raster-order Julia frame engine writing one escape count per pixel into the framebuffer BRAM.
// Define JULIA_MANDEL_EN to add the i_mandel port and the per-frame Mandelbrot mode.
module julia_fb_writer
  import julia_pkg::*;
#(
  parameter int FB_W     = 320,
  parameter int FB_H     = 180,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int FRAC     = FRAC_BITS,
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int X0       = DEF_X0,
  parameter int DX       = DEF_DX,
  parameter int Y0       = DEF_Y0,
  parameter int DY       = DEF_DY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic signed [15:0]       i_c_re,
  input  logic signed [15:0]       i_c_im,
`ifdef JULIA_MANDEL_EN
  input  logic                     i_mandel,
`endif
  output logic                     o_we,
  output logic [ADDR_W-1:0]        o_addr,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int CNT_W = cnt_width(MAX_ITER);
  localparam int PX_W  = $clog2(FB_W);
  localparam int PY_W  = $clog2(FB_H);
  localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(FB_W - 1);
  localparam logic [PY_W-1:0]  PY_LAST  = PY_W'(FB_H - 1);
  localparam logic [CNT_W-1:0] ITER_CAP = CNT_W'(MAX_ITER);
  localparam logic signed [15:0] X0_Q = 16'(X0);
  localparam logic signed [15:0] DX_Q = 16'(DX);
  localparam logic signed [15:0] Y0_Q = 16'(Y0);
  localparam logic signed [15:0] DY_Q = 16'(DY);

  state_t             state;
  logic signed [15:0] c_re, c_im, re_base, im_row, z_re, z_im;
  logic signed [15:0] step_c_re, step_c_im, nz_re, nz_im;
  logic [PX_W-1:0]    px;
  logic [PY_W-1:0]    py;
  logic [ADDR_W-1:0]  addr;
  logic [CNT_W-1:0]   iter;
  logic               escape;
`ifdef JULIA_MANDEL_EN
  logic               mandel;
`endif

  // In Mandelbrot mode the pixel coordinate takes the place of the frame's latched c.
  always_comb begin
    step_c_re = c_re;
    step_c_im = c_im;
`ifdef JULIA_MANDEL_EN
    if (mandel) begin
      step_c_re = re_base;
      step_c_im = im_row;
    end
`endif
  end

  julia_iter_step #(.FRAC(FRAC)) u_step (
    .z_re   (z_re),
    .z_im   (z_im),
    .c_re   (step_c_re),
    .c_im   (step_c_im),
    .nz_re  (nz_re),
    .nz_im  (nz_im),
    .escape (escape)
  );

  // The write strobe is raised on entry to WRITE so it is high for exactly that state's cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      c_re    <= '0;
      c_im    <= '0;
      re_base <= '0;
      im_row  <= '0;
      z_re    <= '0;
      z_im    <= '0;
      px      <= '0;
      py      <= '0;
      addr    <= '0;
      iter    <= '0;
`ifdef JULIA_MANDEL_EN
      mandel  <= 1'b0;
`endif
      o_we    <= 1'b0;
      o_addr  <= '0;
      o_data  <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_we   <= 1'b0;
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            c_re    <= i_c_re;
            c_im    <= i_c_im;
`ifdef JULIA_MANDEL_EN
            mandel  <= i_mandel;
`endif
            px      <= '0;
            py      <= '0;
            addr    <= '0;
            re_base <= X0_Q;
            im_row  <= Y0_Q;
            o_busy  <= 1'b1;
            state   <= INIT;
          end
        end
        INIT: begin
          z_re  <= re_base;
          z_im  <= im_row;
`ifdef JULIA_MANDEL_EN
          if (mandel) begin
            z_re <= '0;
            z_im <= '0;
          end
`endif
          iter  <= '0;
          state <= ITER;
        end
        ITER: begin
          if (escape || iter == ITER_CAP) begin
            o_we   <= 1'b1;
            o_addr <= addr;
            o_data <= DATA_W'(iter);
            state  <= WRITE;
          end else begin
            z_re <= nz_re;
            z_im <= nz_im;
            iter <= iter + CNT_W'(1);
          end
        end
        WRITE: begin
          addr <= addr + ADDR_W'(1);
          if (px == PX_LAST) begin
            px      <= '0;
            py      <= py + PY_W'(1);
            re_base <= X0_Q;
            im_row  <= im_row + DY_Q;
          end else begin
            px      <= px + PX_W'(1);
            re_base <= re_base + DX_Q;
          end
          if (px == PX_LAST && py == PY_LAST) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= IDLE;
          end else begin
            state  <= INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_fb_writer.sv
// Randomized self-checking bench for julia_fb_writer on a reduced 16x9 window with a coarse pixel step.
// Each written count is compared against an iterate-until-escape reference computed per pixel.
module tb_julia_fb_writer;

  localparam int FB_W     = 16;
  localparam int FB_H     = 9;
  localparam int MAX_ITER = 31;
  localparam int X0       = -8192;
  localparam int DX       = 1020;
  localparam int Y0       = 4608;
  localparam int DY       = -1020;
  localparam int NPIX     = FB_W * FB_H;
  localparam int CENTRE   = 4 * FB_W + 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_start;
  logic signed [15:0] i_c_re, i_c_im;
  logic               mandel = 1'b0;
  logic               o_we, o_busy, o_done;
  logic [15:0]        o_addr;
  logic [7:0]         o_data;

  int n_checks = 0;
  int n_fail   = 0;
  int frame_data [NPIX];

  always #5 clk = ~clk;

  julia_fb_writer #(
    .FB_W(FB_W), .FB_H(FB_H), .ADDR_W(16), .DATA_W(8), .FRAC(12), .MAX_ITER(MAX_ITER),
    .X0(X0), .DX(DX), .Y0(Y0), .DY(DY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_c_re  (i_c_re),
    .i_c_im  (i_c_im),
`ifdef JULIA_MANDEL_EN
    .i_mandel(mandel),
`endif
    .o_we    (o_we),
    .o_addr  (o_addr),
    .o_data  (o_data),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  // Escape count of one pixel: iterate from the pixel coordinate until |z|^2 > 4.0 or the cap.
  function automatic int modelCount(input int px, input int py, input int cre, input int cim);
    int zr, zi, r2, i2, ri;
    zr = X0 + px * DX;
    zi = Y0 + py * DY;
    for (int n = 0; n < MAX_ITER; n++) begin
      r2 = (zr * zr) >>> 12;
      i2 = (zi * zi) >>> 12;
      ri = (zr * zi) >>> 12;
      if (r2 + i2 > 16384) return n;
      zr = wrap16(r2 - i2 + cre);
      zi = wrap16(2 * ri + cim);
    end
    return MAX_ITER;
  endfunction

  task automatic applyStimulus(input bit wait_edge, input int cre, input int cim);
    if (wait_edge) @(negedge clk);
    i_c_re  = 16'(cre);
    i_c_im  = 16'(cim);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    checkOutput("busy after start", o_busy, 1);
  endtask

  // Follows one frame; optionally pokes a start with a new c, or asserts reset, after a given write.
  task automatic runFrame(input string name, input int cre, input int cim, input int poke_at,
                          input int rst_at, output int nw, output int nd);
    int  cyc;
    bit  stop;
    nw = 0; nd = 0; cyc = 0; stop = 0;
    while (!stop && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (i_start) i_start = 1'b0;
      if (o_we) begin
        checkOutput({name, " addr"}, o_addr, nw);
        if (nw < NPIX) begin
          frame_data[nw] = int'(o_data);
          checkOutput({name, " data"}, o_data, modelCount(nw % FB_W, nw / FB_W, cre, cim));
        end
        nw++;
        if (nw == poke_at) begin
          i_start = 1'b1;
          i_c_re  = 16'(cre + 1234);
        end
        if (nw == rst_at) begin
          rst  = 1'b1;
          stop = 1'b1;
        end
      end
      if (o_done) begin
        nd++;
        stop = 1'b1;
        checkOutput({name, " busy at done"}, o_busy, 0);
      end
    end
    checkOutput({name, " timeout"}, (cyc >= 20000) ? 1 : 0, 0);
  endtask

  task automatic postCheck(input string name, input int ncyc);
    int extra;
    extra = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (o_we || o_done) extra++;
    end
    checkOutput({name, " quiet after"}, extra, 0);
    checkOutput({name, " busy after"}, o_busy, 0);
  endtask

  initial begin
    int nw, nd, cre, cim;
    rst = 1'b1; i_start = 1'b0; i_c_re = '0; i_c_im = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset we", o_we, 0);
    checkOutput("reset addr", o_addr, 0);
    checkOutput("reset data", o_data, 0);
    checkOutput("reset busy", o_busy, 0);
    checkOutput("reset done", o_done, 0);
    rst = 1'b0;

    applyStimulus(1, 0, 0);
    runFrame("c0", 0, 0, -1, -1, nw, nd);
    checkOutput("c0 writes", nw, NPIX);
    checkOutput("c0 dones", nd, 1);
    checkOutput("c0 pixel0", frame_data[0], 0);
    checkOutput("c0 centre", frame_data[CENTRE], MAX_ITER);
    postCheck("c0", 5);

    applyStimulus(1, -3277, 0);
    runFrame("c-0.8", -3277, 0, -1, -1, nw, nd);
    checkOutput("c-0.8 writes", nw, NPIX);
    checkOutput("c-0.8 dones", nd, 1);
    postCheck("c-0.8", 5);

    repeat (2) begin
      cre = int'($urandom_range(0, 8191)) - 4096;
      cim = int'($urandom_range(0, 8191)) - 4096;
      applyStimulus(1, cre, cim);
      runFrame("rand", cre, cim, -1, -1, nw, nd);
      checkOutput("rand writes", nw, NPIX);
      checkOutput("rand dones", nd, 1);
      postCheck("rand", 3);
    end

    applyStimulus(1, -3277, 1000);
    runFrame("poke", -3277, 1000, 50, -1, nw, nd);
    checkOutput("poke writes", nw, NPIX);
    checkOutput("poke dones", nd, 1);

    // Start again in the very cycle o_done is high.
    cre = int'($urandom_range(0, 8191)) - 4096;
    applyStimulus(0, cre, 500);
    runFrame("chain", cre, 500, -1, -1, nw, nd);
    checkOutput("chain writes", nw, NPIX);
    checkOutput("chain dones", nd, 1);
    postCheck("chain", 5);

    applyStimulus(1, -3277, 0);
    runFrame("abort", -3277, 0, -1, 50, nw, nd);
    @(negedge clk);
    checkOutput("abort we", o_we, 0);
    checkOutput("abort busy", o_busy, 0);
    checkOutput("abort writes", nw, 50);
    checkOutput("abort dones", nd, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    postCheck("abort", 20);

    applyStimulus(1, 0, 0);
    runFrame("restart", 0, 0, -1, -1, nw, nd);
    checkOutput("restart writes", nw, NPIX);
    checkOutput("restart dones", nd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
